// File: rtl/ex_bus_pkg.sv
// ex_bus_pkg: shared types for the MSX cartridge bus cycle sequencer.
// FSM states, cycle-type codes, T-state counts and the bus output bundle.
package ex_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3,
        ST_DONE
    } state_t;

    typedef logic [2:0] cyc_t;

    localparam cyc_t CYC_MEM_RD = 3'd0;
    localparam cyc_t CYC_MEM_WR = 3'd1;
    localparam cyc_t CYC_IO_RD  = 3'd2;
    localparam cyc_t CYC_IO_WR  = 3'd3;
    localparam cyc_t CYC_M1     = 3'd4;

    // Nominal cycle lengths in T-states with default forced waits.
    localparam int T_BASE = 3;
    localparam int T_MEM  = T_BASE;
    localparam int T_M1   = T_BASE + 1;
    localparam int T_IO   = T_BASE + 1;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data_o;
        logic        data_oe;
        logic        reverse_n;
        logic        mreq_n;
        logic        iorq_n;
        logic        rd_n;
        logic        wr_n;
        logic        m1_n;
    } bus_out_t;

    localparam bus_out_t BUS_RESET = '{
        addr:      16'h0000,
        data_o:    8'h00,
        data_oe:   1'b0,
        reverse_n: 1'b1,
        mreq_n:    1'b1,
        iorq_n:    1'b1,
        rd_n:      1'b1,
        wr_n:      1'b1,
        m1_n:      1'b1
    };

    // M1 is only honoured on a plain memory read; anything else
    // degrades to the matching plain cycle.
    function automatic cyc_t cyc_decode(
        input logic io,
        input logic wr,
        input logic m1
    );
        cyc_t c;
        if (m1 && !io && !wr) c = CYC_M1;
        else if (io && wr)    c = CYC_IO_WR;
        else if (io)          c = CYC_IO_RD;
        else if (wr)          c = CYC_MEM_WR;
        else                  c = CYC_MEM_RD;
        return c;
    endfunction

    function automatic logic cyc_is_io(input cyc_t c);
        return (c == CYC_IO_RD) || (c == CYC_IO_WR);
    endfunction

    function automatic logic cyc_is_wr(input cyc_t c);
        return (c == CYC_MEM_WR) || (c == CYC_IO_WR);
    endfunction

    // Strobes idle, data pins released, address and data held.
    function automatic bus_out_t release_bus(input bus_out_t b);
        bus_out_t r;
        r           = b;
        r.mreq_n    = 1'b1;
        r.iorq_n    = 1'b1;
        r.rd_n      = 1'b1;
        r.wr_n      = 1'b1;
        r.m1_n      = 1'b1;
        r.data_oe   = 1'b0;
        r.reverse_n = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/ex_bus_cycle_sequencer_if.sv
// ex_bus_cycle_sequencer_if: internal request/ack handshake plus external
// cartridge bus pins. master = requester/slot side, slave = sequencer.
interface ex_bus_cycle_sequencer_if;

    logic        req;
    logic        req_io;
    logic        req_wr;
    logic        req_m1;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack;
    logic        err;
    logic [7:0]  rdata;
    logic        busy;

    logic [15:0] ex_bus_addr;
    logic [7:0]  ex_bus_data_o;
    logic        ex_bus_data_oe;
    logic [7:0]  ex_bus_data_i;
    logic        ex_bus_data_reverse_n;
    logic        ex_bus_mreq_n;
    logic        ex_bus_iorq_n;
    logic        ex_bus_rd_n;
    logic        ex_bus_wr_n;
    logic        ex_bus_m1_n;
    logic        ex_bus_wait_n;

    modport master (
        output req, req_io, req_wr, req_m1, req_addr, req_wdata,
        input  ack, err, rdata, busy,
        input  ex_bus_addr, ex_bus_data_o, ex_bus_data_oe,
        input  ex_bus_data_reverse_n,
        input  ex_bus_mreq_n, ex_bus_iorq_n, ex_bus_rd_n,
        input  ex_bus_wr_n, ex_bus_m1_n,
        output ex_bus_data_i, ex_bus_wait_n
    );

    modport slave (
        input  req, req_io, req_wr, req_m1, req_addr, req_wdata,
        output ack, err, rdata, busy,
        output ex_bus_addr, ex_bus_data_o, ex_bus_data_oe,
        output ex_bus_data_reverse_n,
        output ex_bus_mreq_n, ex_bus_iorq_n, ex_bus_rd_n,
        output ex_bus_wr_n, ex_bus_m1_n,
        input  ex_bus_data_i, ex_bus_wait_n
    );

endinterface

// File: rtl/ex_bus_sync.sv
// ex_bus_sync: STAGES-deep flop synchronizer, resets to 1 (idle level).
// Ports: clk, rst (async high), d (async in), q (synced out).
module ex_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '1;
        else     ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/ex_bus_cycle_sequencer.sv
// ex_bus_cycle_sequencer: runs one Z80-style mem/io/M1 cycle on the MSX
// cartridge bus per request. Ports: clk_108m, reset (async high),
// clk_enable_3m6 (T-state strobe), bus (request side + ex_bus pins).
module ex_bus_cycle_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int M1_WAITS    = 1,
    parameter int IO_WAITS    = 1,
    parameter int TIMEOUT_T   = 255
) (
    input  logic                          clk_108m,
    input  logic                          reset,
    input  logic                          clk_enable_3m6,
    ex_bus_cycle_sequencer_if.slave       bus
);

    import ex_bus_pkg::*;

    localparam logic [7:0] M1_W   = 8'(M1_WAITS);
    localparam logic [7:0] IO_W   = 8'(IO_WAITS);
    localparam logic [7:0] TO_MAX = 8'(TIMEOUT_T);

    state_t     state_q, state_d;
    cyc_t       cyc_q, cyc_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] tocnt_q, tocnt_d;
    bus_out_t   bo_q, bo_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [7:0] rdata_q, rdata_d;
    logic       wait_s;

    ex_bus_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk_108m),
        .rst (reset),
        .d   (bus.ex_bus_wait_n),
        .q   (wait_s)
    );

    always_ff @(posedge clk_108m or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= CYC_MEM_RD;
            wcnt_q  <= 8'd0;
            tocnt_q <= 8'd0;
            bo_q    <= BUS_RESET;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            wcnt_q  <= wcnt_d;
            tocnt_q <= tocnt_d;
            bo_q    <= bo_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        wcnt_d  = wcnt_q;
        tocnt_d = tocnt_q;
        bo_d    = bo_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (clk_enable_3m6 && bus.req) begin
                    cyc_d     = cyc_decode(bus.req_io, bus.req_wr,
                                           bus.req_m1);
                    bo_d.addr = bus.req_addr;
                    bo_d.m1_n = (cyc_d != CYC_M1);
                    if (cyc_is_wr(cyc_d)) begin
                        bo_d.reverse_n = 1'b0;
                        bo_d.data_oe   = 1'b1;
                        bo_d.data_o    = bus.req_wdata;
                    end
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                if (clk_enable_3m6) begin
                    if (cyc_is_io(cyc_q)) bo_d.iorq_n = 1'b0;
                    else                  bo_d.mreq_n = 1'b0;
                    if (cyc_is_wr(cyc_q)) bo_d.wr_n = 1'b0;
                    else                  bo_d.rd_n = 1'b0;
                    if (cyc_q == CYC_M1)        wcnt_d = M1_W;
                    else if (cyc_is_io(cyc_q))  wcnt_d = IO_W;
                    else                        wcnt_d = 8'd0;
                    tocnt_d = 8'd0;
                    state_d = ST_T2;
                end
            end
            ST_T2, ST_TW: begin
                if (clk_enable_3m6) begin
                    if (wcnt_q != 8'd0) begin
                        // Forced waits never count toward the timeout.
                        wcnt_d  = wcnt_q - 8'd1;
                        state_d = ST_TW;
                    end else if (!wait_s) begin
                        if (tocnt_q == TO_MAX) begin
                            bo_d    = release_bus(bo_q);
                            err_d   = 1'b1;
                            ack_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            tocnt_d = tocnt_q + 8'd1;
                            state_d = ST_TW;
                        end
                    end else begin
                        state_d = ST_T3;
                    end
                end
            end
            ST_T3: begin
                if (clk_enable_3m6) begin
                    if (!cyc_is_wr(cyc_q)) rdata_d = bus.ex_bus_data_i;
                    bo_d    = release_bus(bo_q);
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ack                   = ack_q;
    assign bus.err                   = err_q;
    assign bus.rdata                 = rdata_q;
    assign bus.busy                  = busy_q;
    assign bus.ex_bus_addr           = bo_q.addr;
    assign bus.ex_bus_data_o         = bo_q.data_o;
    assign bus.ex_bus_data_oe        = bo_q.data_oe;
    assign bus.ex_bus_data_reverse_n = bo_q.reverse_n;
    assign bus.ex_bus_mreq_n         = bo_q.mreq_n;
    assign bus.ex_bus_iorq_n         = bo_q.iorq_n;
    assign bus.ex_bus_rd_n           = bo_q.rd_n;
    assign bus.ex_bus_wr_n           = bo_q.wr_n;
    assign bus.ex_bus_m1_n           = bo_q.m1_n;

endmodule
